// File: rtl/mem_port_arbiter2_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
package mem_port_arbiter2_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_t;

endpackage

// File: rtl/mem_port_arbiter2_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
interface mem_port_arbiter2_if;
  import mem_port_arbiter2_pkg::*;

  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              we0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              we1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // Arbiter side
  modport slave (
    input  req0, addr0, wdata0, we0,
    input  req1, addr1, wdata1, we1,
    input  mem_rdata, mem_ready,
    output gnt0, gnt1, done0, done1, err, rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus memory
  modport master (
    output req0, addr0, wdata0, we0,
    output req1, addr1, wdata1, we1,
    output mem_rdata, mem_ready,
    input  gnt0, gnt1, done0, done1, err, rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter2_mux.sv
// 32-bit 2:1 mux used for the shared address and write-data paths.
module mux32_32_32 #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic              sel,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? a1 : a0;

endmodule

// File: rtl/mem_port_arbiter2.sv
// Round-robin arbiter for one shared memory port: grants a requester, runs the
// req/ready handshake, returns read data with a done pulse, aborts stalls.
module mem_port_arbiter2
  import mem_port_arbiter2_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter2_if.slave   bus
);

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              prio_q, prio_d;
  logic [CW-1:0]     wdog_q, wdog_d;
  logic              done0_q, done1_q, err_q;
  logic [DATA_W-1:0] rdata_q;

  logic gnt0, gnt1, busy, wdog_hit, finish, owner;

  assign gnt0     = (state_q == ST_BUSY0);
  assign gnt1     = (state_q == ST_BUSY1);
  assign busy     = gnt0 | gnt1;
  assign owner    = gnt1;
  assign wdog_hit = (TIMEOUT != 0) && (wdog_q == CW'(TIMEOUT - 1));
  // mem_ready takes precedence over a simultaneous watchdog expiry
  assign finish   = busy && (bus.mem_ready || wdog_hit);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    wdog_d  = wdog_q;
    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (bus.req0 && bus.req1) begin
          sel_d   = prio_q;
          state_d = prio_q ? ST_BUSY1 : ST_BUSY0;
        end else if (bus.req0) begin
          sel_d   = 1'b0;
          state_d = ST_BUSY0;
        end else if (bus.req1) begin
          sel_d   = 1'b1;
          state_d = ST_BUSY1;
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        if (finish) begin
          state_d = ST_IDLE;
          prio_d  = ~owner;
        end else begin
          wdog_d = wdog_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
      wdog_q  <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      wdog_q  <= wdog_d;
      done0_q <= finish && !owner;
      done1_q <= finish && owner;
      err_q   <= finish && !bus.mem_ready;
      if (finish && bus.mem_ready) rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.err     = err_q;
  assign bus.rdata   = rdata_q;
  assign bus.mem_req = busy;
  assign bus.mem_we  = busy & (sel_q ? bus.we1 : bus.we0);

  mux32_32_32 #(.DATA_W(ADDR_W)) u_addr_mux (
    .a0  (bus.addr0),
    .a1  (bus.addr1),
    .sel (sel_q),
    .y   (bus.mem_addr)
  );

  mux32_32_32 #(.DATA_W(DATA_W)) u_wdata_mux (
    .a0  (bus.wdata0),
    .a1  (bus.wdata1),
    .sel (sel_q),
    .y   (bus.mem_wdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter2.sv
// Scoreboard bench for mem_port_arbiter2: directed accesses push expected
// completions; a negedge monitor pops and compares on every done pulse.
module tb_mem_port_arbiter2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter2_if bus_if ();

  mem_port_arbiter2 #(.TIMEOUT(16), .CW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          len;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mem_lat = 0;
  int   busy_cnt = 0;
  int   run = 0;
  logic stray = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h8C08_0004;
    return a ^ 32'hFFFF_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic checkint(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int port, input logic err, input logic [31:0] rd, input int len);
    exp_t e;
    e.port = port; e.err = err; e.rdata = rd; e.len = len;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(output int which, output int at);
    int n = 0;
    which = -1;
    at = -1;
    while ((bus_if.gnt0 | bus_if.gnt1) && n < 64) begin tick(); n++; end
    while (!(bus_if.gnt0 | bus_if.gnt1) && n < 64) begin tick(); n++; end
    checks++;
    if (n >= 64) begin
      failures++;
      $display("FAIL wait_gnt: no grant after %0d cycles, required a grant", n);
    end else begin
      which = bus_if.gnt1 ? 1 : 0;
      at = cyc;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin tick(); n++; end
    checkint("drain_pending", sb.size(), 0);
  endtask

  // Memory responder: ready after mem_lat BUSY cycles (0 = never)
  always begin
    @(posedge clk);
    #1;
    if (bus_if.mem_req === 1'b1) begin
      busy_cnt++;
      bus_if.mem_ready = (mem_lat > 0) && (busy_cnt == mem_lat);
    end else begin
      busy_cnt = 0;
      bus_if.mem_ready = stray;
    end
    bus_if.mem_rdata = mem_model(bus_if.mem_addr);
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ((bus_if.gnt0 & bus_if.gnt1) !== 1'b0) begin
        failures++;
        $display("FAIL gnt_overlap: gnt0=%b gnt1=%b required not both", bus_if.gnt0, bus_if.gnt1);
      end
      if (bus_if.done0 | bus_if.done1) begin
        checks++;
        if (bus_if.done0 & bus_if.done1) begin
          failures++;
          $display("FAIL done_overlap: done0=1 done1=1 required one-hot");
        end
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: done0=%b done1=%b required none", bus_if.done0, bus_if.done1);
        end else begin
          mon_e = sb.pop_front();
          checkint("done_port", bus_if.done1 ? 1 : 0, mon_e.port);
          check32("done_err", {31'd0, bus_if.err}, {31'd0, mon_e.err});
          check32("done_rdata", bus_if.rdata, mon_e.rdata);
          checkint("busy_len", run, mon_e.len);
        end
        run = 0;
      end else if (bus_if.mem_req === 1'b1) begin
        run++;
      end else begin
        run = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int w, at, prev, t0;
    rst_n = 1'b0;
    bus_if.req0 = 0; bus_if.addr0 = '0; bus_if.wdata0 = '0; bus_if.we0 = 0;
    bus_if.req1 = 0; bus_if.addr1 = '0; bus_if.wdata1 = '0; bus_if.we1 = 0;
    repeat (3) tick();
    check32("rst_gnt", {30'd0, bus_if.gnt1, bus_if.gnt0}, 32'd0);
    check32("rst_done", {30'd0, bus_if.done1, bus_if.done0}, 32'd0);
    check32("rst_err_req", {30'd0, bus_if.err, bus_if.mem_req}, 32'd0);
    check32("rst_rdata", bus_if.rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // Tie: both held, alternate 0,1,0,1 with one IDLE cycle between
    mem_lat = 2;
    bus_if.addr0 = 32'h0040_0010; bus_if.addr1 = 32'h1001_0004;
    push(0, 0, 32'hFFBF_0010, 2); push(1, 0, 32'hEFFE_0004, 2);
    push(0, 0, 32'hFFBF_0010, 2); push(1, 0, 32'hEFFE_0004, 2);
    bus_if.req0 = 1; bus_if.req1 = 1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(w, at);
      checkint("tie_order", w, k % 2);
      if (k > 0) checkint("tie_gap", at - prev, 3);
      prev = at;
      if (k == 3) begin bus_if.req0 = 0; bus_if.req1 = 0; end
    end
    wait_drain();

    // Single read, ready in cycle 3, done in cycle 4
    mem_lat = 3;
    bus_if.addr0 = 32'h0040_0000;
    push(0, 0, 32'h8C08_0004, 3);
    t0 = cyc;
    bus_if.req0 = 1;
    wait_gnt(w, at);
    checkint("single_gnt_cycle", at - t0, 1);
    tick(); tick();
    check32("single_gnt_c3", {31'd0, bus_if.gnt0}, 32'd1);
    bus_if.req0 = 0;
    tick();
    check32("single_done_c4", {31'd0, bus_if.done0}, 32'd1);
    check32("single_gnt_off", {31'd0, bus_if.gnt0}, 32'd0);
    wait_drain();

    // Write from requester 1
    mem_lat = 2;
    bus_if.addr0 = 32'h0040_0000; bus_if.wdata0 = 32'h1234_5678; bus_if.we0 = 0;
    bus_if.addr1 = 32'h1001_0000; bus_if.wdata1 = 32'hDEAD_BEEF; bus_if.we1 = 1;
    push(1, 0, 32'hEFFE_0000, 2);
    bus_if.req1 = 1;
    wait_gnt(w, at);
    checkint("write_owner", w, 1);
    check32("write_we", {31'd0, bus_if.mem_we}, 32'd1);
    check32("write_addr", bus_if.mem_addr, 32'h1001_0000);
    check32("write_wdata", bus_if.mem_wdata, 32'hDEAD_BEEF);
    bus_if.req1 = 0;
    tick(); tick();
    check32("write_we_gated", {31'd0, bus_if.mem_we}, 32'd0);
    wait_drain();
    bus_if.we1 = 0;

    // Watchdog abort keeps old rdata; ready on the last cycle wins
    mem_lat = 0;
    bus_if.addr0 = 32'h0040_0020;
    push(0, 1, 32'hEFFE_0000, 16);
    bus_if.req0 = 1;
    wait_gnt(w, at);
    bus_if.req0 = 0;
    wait_drain();
    mem_lat = 16;
    bus_if.addr0 = 32'h0040_0030;
    push(0, 0, 32'hFFBF_0030, 16);
    bus_if.req0 = 1;
    wait_gnt(w, at);
    bus_if.req0 = 0;
    wait_drain();

    // Dropped req still completes; stray ready in IDLE is ignored
    mem_lat = 3;
    bus_if.addr0 = 32'h0040_0040;
    push(0, 0, 32'hFFBF_0040, 3);
    bus_if.req0 = 1;
    wait_gnt(w, at);
    bus_if.req0 = 0;
    wait_drain();
    stray = 1'b1;
    repeat (3) begin
      tick();
      check32("stray_idle", {31'd0, bus_if.mem_req}, 32'd0);
    end
    stray = 1'b0;
    tick();
    check32("stray_rdata", bus_if.rdata, 32'hFFBF_0040);

    // Reset in second BUSY1 cycle: silent drop, then tie goes to req0
    mem_lat = 0;
    bus_if.addr1 = 32'h1001_0008;
    bus_if.req1 = 1;
    wait_gnt(w, at);
    checkint("rst_mid_owner", w, 1);
    tick();
    rst_n = 1'b0;
    tick();
    check32("rst_mid_gnt", {30'd0, bus_if.gnt1, bus_if.gnt0}, 32'd0);
    check32("rst_mid_done", {30'd0, bus_if.done1, bus_if.done0}, 32'd0);
    check32("rst_mid_err_req", {30'd0, bus_if.err, bus_if.mem_req}, 32'd0);
    check32("rst_mid_rdata", bus_if.rdata, 32'd0);
    rst_n = 1'b1;
    mem_lat = 1;
    bus_if.addr0 = 32'h0040_0050;
    push(0, 0, 32'hFFBF_0050, 1); push(1, 0, 32'hEFFE_0008, 1);
    bus_if.req0 = 1;
    wait_gnt(w, at);
    checkint("post_rst_tie", w, 0);
    bus_if.req0 = 0;
    wait_gnt(w, at);
    checkint("post_rst_next", w, 1);
    bus_if.req1 = 0;
    wait_drain();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
